// File: rtl/conv3x3_seq_ctrl.sv
// Read/enable/write sequencer for the 3x3 window adder over an IMG_W x IMG_H line memory.
// Optional macro CONV3X3_SEQ_CTRL_PERF_EN adds a saturating busy-cycle counter output.
module conv3x3_seq_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H),
    // A single-window image still needs a one-bit address port.
    parameter int OUT_AW = ((IMG_W-2)*(IMG_H-2) > 1) ? $clog2((IMG_W-2)*(IMG_H-2)) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ROW_W-1:0]  rd_row,
    output logic [COL_W-1:0]  rd_col,
    output logic [1:0]        adder_addr,
    output logic              adder_en,
    output logic              adder_end,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        mod3_q, mod3_d;
    logic              drain_q, drain_d;
    logic [1:0]        adder_addr_q, adder_addr_d;
    logic              adder_en_q, adder_en_d;
    logic              adder_end_q, adder_end_d;
    logic              wr_en_q, wr_en_d;
    logic [OUT_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic              issue, last_issue, start_acc;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        mod3_d     = mod3_q;
        drain_d    = drain_q;
        wr_cnt_d   = wr_cnt_q;
        issue      = 1'b0;
        last_issue = 1'b0;
        start_acc  = 1'b0;

        if (wr_en_q) begin
            wr_cnt_d = wr_cnt_q + OUT_AW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    col_d     = '0;
                    row_d     = '0;
                    mod3_d    = '0;
                    wr_cnt_d  = '0;
                    start_acc = 1'b1;
                end
            end
            S_RUN: begin
                issue      = 1'b1;
                last_issue = (col_q == COL_W'(IMG_W-1)) && (row_q == ROW_W'(IMG_H-3));
                if (last_issue) begin
                    // Counters hold so rd_row/rd_col keep the final read address.
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else if (col_q == COL_W'(IMG_W-1)) begin
                    col_d  = '0;
                    row_d  = row_q + ROW_W'(1);
                    mod3_d = '0;
                end else begin
                    col_d  = col_q + COL_W'(1);
                    mod3_d = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        adder_addr_d = issue ? mod3_q : 2'd0;
        adder_en_d   = issue && (col_q >= COL_W'(2));
        adder_end_d  = issue && last_issue && (col_q >= COL_W'(2));
        wr_en_d      = adder_en_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            mod3_q       <= '0;
            drain_q      <= 1'b0;
            adder_addr_q <= '0;
            adder_en_q   <= 1'b0;
            adder_end_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mod3_q       <= mod3_d;
            drain_q      <= drain_d;
            adder_addr_q <= adder_addr_d;
            adder_en_q   <= adder_en_d;
            adder_end_q  <= adder_end_d;
            wr_en_q      <= wr_en_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign rd_en      = issue;
    assign rd_row     = row_q;
    assign rd_col     = col_q;
    assign adder_addr = adder_addr_q;
    assign adder_en   = adder_en_q;
    assign adder_end  = adder_end_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_cnt_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

`ifdef CONV3X3_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Directed bench for conv3x3_seq_ctrl: 8x8 timing table, full-run scan against an
// adder/memory model, ignored starts, mid-run reset, and a minimal 3x3 image.
module tb_conv3x3_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8x8 instance
    logic       start = 1'b0;
    logic       busy, done, rd_en, adder_en, adder_end, wr_en;
    logic [2:0] rd_row, rd_col;
    logic [1:0] adder_addr;
    logic [5:0] wr_addr;
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles, s_perf_cycles;
`endif

    conv3x3_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .adder_addr(adder_addr), .adder_en(adder_en), .adder_end(adder_end),
        .wr_en(wr_en), .wr_addr(wr_addr)
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // 3x3 instance
    logic       s_start = 1'b0;
    logic       s_busy, s_done, s_rd_en, s_adder_en, s_adder_end, s_wr_en;
    logic [1:0] s_rd_row, s_rd_col, s_adder_addr;
    logic [0:0] s_wr_addr;

    conv3x3_seq_ctrl #(.IMG_W(3), .IMG_H(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_row(s_rd_row), .rd_col(s_rd_col),
        .adder_addr(s_adder_addr), .adder_en(s_adder_en), .adder_end(s_adder_end),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr)
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
        , .perf_cycles(s_perf_cycles)
`endif
    );

    // Line memory with pixel(r,c)=r*8+c returning the 3-row column sum, plus adder model.
    function automatic int col_sum(input int r, input int c);
        return 24 * r + 24 + 3 * c;
    endfunction

    int   din_q;
    logic v1_q = 1'b0;
    int   slot [3];
    int   wdata;

    always @(posedge clk) begin
        v1_q <= rd_en;
        if (rd_en) din_q <= col_sum(int'(rd_row), int'(rd_col));
        if (v1_q) begin
            slot[int'(adder_addr)] <= din_q;
            if (adder_en)
                wdata <= din_q + slot[(int'(adder_addr) + 1) % 3] + slot[(int'(adder_addr) + 2) % 3];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd_en;
        logic [2:0] row, col;
        logic [1:0] aa;
        logic       ae, aend, we;
        logic [5:0] wa;
        logic       busy, done;
        int         wd;
    } obs_t;

    obs_t obs [64];

    // Runs ncyc cycles starting at cycle 0 with start high; optional extra start and reset pulse.
    task automatic capture(input int ncyc, input int extra_start, input int rst_cyc);
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == extra_start);
            if (c == rst_cyc) rst_n = 1'b0;
            if (c == rst_cyc + 2) rst_n = 1'b1;
            @(negedge clk);
            obs[c] = '{rd_en, rd_row, rd_col, adder_addr, adder_en, adder_end,
                       wr_en, wr_addr, busy, done, wdata};
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    // Checks a complete 8x8 run captured over 56 cycles against the expected schedule.
    task automatic check_run(input string tag);
        int wcnt = 0;
        int first_we = -1;
        int last_we = -1;
        for (int c = 0; c < 56; c++) begin
            check($sformatf("%s rd_en c%0d", tag, c), int'(obs[c].rd_en), int'(c >= 1 && c <= 48));
            check($sformatf("%s busy c%0d", tag, c), int'(obs[c].busy), int'(c >= 1 && c <= 50));
            check($sformatf("%s done c%0d", tag, c), int'(obs[c].done), int'(c == 51));
            if (c >= 1 && c <= 48) begin
                check($sformatf("%s rd_row c%0d", tag, c), int'(obs[c].row), (c - 1) / 8);
                check($sformatf("%s rd_col c%0d", tag, c), int'(obs[c].col), (c - 1) % 8);
            end
            if (c >= 2 && c <= 49) begin
                int col = (c - 2) % 8;
                check($sformatf("%s adder_addr c%0d", tag, c), int'(obs[c].aa), col % 3);
                check($sformatf("%s adder_en c%0d", tag, c), int'(obs[c].ae), int'(col >= 2));
            end else begin
                check($sformatf("%s adder_en c%0d", tag, c), int'(obs[c].ae), 0);
            end
            check($sformatf("%s adder_end c%0d", tag, c), int'(obs[c].aend), int'(c == 49));
            if (obs[c].we) begin
                int r  = wcnt / 6;
                int cc = wcnt % 6;
                if (first_we < 0) first_we = c;
                last_we = c;
                check($sformatf("%s wr_addr c%0d", tag, c), int'(obs[c].wa), wcnt);
                check($sformatf("%s wdata c%0d", tag, c), obs[c].wd, 72 * r + 9 * cc + 81);
                wcnt++;
            end
        end
        check({tag, " wr_en count"}, wcnt, 36);
        check({tag, " first wr_en cycle"}, first_we, 5);
        check({tag, " last wr_en cycle"}, last_we, 50);
    endtask

    // -1 marks a don't-care field.
    typedef struct {
        int cyc, rd_en, row, col, aa, ae, aend, we, wa, busy, done;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs = '{
            '{ 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0},
            '{ 1, 1, 0, 0, -1, 0, 0, 0,  0, 1, 0},
            '{ 2, 1, 0, 1,  0, 0, 0, 0,  0, 1, 0},
            '{ 3, 1, 0, 2,  1, 0, 0, 0,  0, 1, 0},
            '{ 4, 1, 0, 3,  2, 1, 0, 0,  0, 1, 0},
            '{ 5, 1, 0, 4,  0, 1, 0, 1,  0, 1, 0},
            '{ 6, 1, 0, 5,  1, 1, 0, 1,  1, 1, 0},
            '{ 9, 1, 1, 0,  1, 1, 0, 1,  4, 1, 0},
            '{10, 1, 1, 1,  0, 0, 0, 1,  5, 1, 0},
            '{11, 1, 1, 2,  1, 0, 0, 0,  6, 1, 0},
            '{12, 1, 1, 3,  2, 1, 0, 0,  6, 1, 0},
            '{13, 1, 1, 4,  0, 1, 0, 1,  6, 1, 0},
            '{48, 1, 5, 7,  0, 1, 0, 1, 33, 1, 0},
            '{49, 0, 5, 7,  1, 1, 1, 1, 34, 1, 0},
            '{50, 0, 5, 7, -1, 0, 0, 1, 35, 1, 0},
            '{51, 0, 5, 7, -1, 0, 0, 0, 36, 0, 1},
            '{52, 0, 5, 7, -1, 0, 0, 0, 36, 0, 0}
        };

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", int'({rd_en, rd_row, rd_col, adder_addr, adder_en, adder_end,
                                     wr_en, wr_addr, busy, done}), 0);
        check("reset small outputs", int'({s_rd_en, s_rd_row, s_rd_col, s_adder_addr, s_adder_en,
                                           s_adder_end, s_wr_en, s_wr_addr, s_busy, s_done}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run 1: nominal 8x8 scan.
        capture(56, -1, -1);
        foreach (vecs[i]) begin
            vec_t v = vecs[i];
            obs_t o = obs[v.cyc];
            int   a [10] = '{int'(o.rd_en), int'(o.row), int'(o.col), int'(o.aa), int'(o.ae),
                             int'(o.aend), int'(o.we), int'(o.wa), int'(o.busy), int'(o.done)};
            int   e [10] = '{v.rd_en, v.row, v.col, v.aa, v.ae, v.aend, v.we, v.wa, v.busy, v.done};
            for (int f = 0; f < 10; f++)
                if (e[f] >= 0) check($sformatf("vec c%0d field%0d", v.cyc, f), a[f], e[f]);
        end
        check_run("run1");
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
        check("perf 8x8", int'(perf_cycles), 50);
`endif

        // Run 2: start mid-run is ignored.
        capture(56, 20, -1);
        check_run("restart_ignored");

        // Run 3: start coinciding with done is ignored (no issue at 52..55).
        capture(56, 51, -1);
        check_run("start_at_done");

        // Run 4: reset at cycle 30 clears everything at once and nothing follows.
        begin
            int late = 0;
            capture(60, -1, 30);
            check("midreset outputs zero", int'({obs[30].rd_en, obs[30].row, obs[30].col, obs[30].aa,
                                                  obs[30].ae, obs[30].aend, obs[30].we, obs[30].wa,
                                                  obs[30].busy, obs[30].done}), 0);
            for (int c = 31; c < 60; c++)
                late += int'(obs[c].we) + int'(obs[c].done) + int'(obs[c].rd_en) + int'(obs[c].busy);
            check("midreset no activity after", late, 0);
        end
        capture(56, -1, -1);
        check_run("after_reset");

        // 3x3 image on the second instance.
        begin
            int s_rd = 0, s_rd_bad = 0, s_we = 0, s_we_cyc = -1, s_wa = -1, s_done_cyc = -1;
            for (int c = 0; c < 10; c++) begin
                s_start = (c == 0);
                @(negedge clk);
                if (s_rd_en) begin
                    s_rd++;
                    if (c < 1 || c > 3 || int'(s_rd_col) != c - 1 || s_rd_row != 2'd0) s_rd_bad++;
                end
                if (s_wr_en) begin
                    s_we++;
                    s_we_cyc = c;
                    s_wa = int'(s_wr_addr);
                end
                if (s_done) s_done_cyc = c;
                @(posedge clk);
                #1;
            end
            s_start = 1'b0;
            check("3x3 issue count", s_rd, 3);
            check("3x3 issue placement", s_rd_bad, 0);
            check("3x3 wr_en count", s_we, 1);
            check("3x3 wr_en cycle", s_we_cyc, 5);
            check("3x3 wr_addr", s_wa, 0);
            check("3x3 done cycle", s_done_cyc, 6);
`ifdef CONV3X3_SEQ_CTRL_PERF_EN
            check("3x3 perf", int'(s_perf_cycles), 5);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
